sprite_anim_renderer: RTL

//  Parametrised animated-sprite pixel generator for the VGA fighter pipeline.

---
 rtl/sprite_anim_renderer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sprite_anim_renderer.sv
// Animated sprite pixel generator: maps the scan position into a scaled, optionally mirrored
// hitbox, addresses a multi-frame sprite ROM and returns registered palette colour plus opacity.
module sprite_anim_renderer #(
   parameter int SPR_W      = 60,
   parameter int SPR_H      = 90,
   parameter int BOX_W      = 80,
   parameter int BOX_H      = 160,
   parameter int NUM_FRAMES = 4,
   parameter int FRAME_HOLD = 8,
   parameter int IDX_W      = 3,
   parameter int TRANSP_IDX = 0,
   parameter int ADDR_W     = $clog2(NUM_FRAMES*SPR_W*SPR_H),
   parameter int FI_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic              vga_clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              frame_tick,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              flip,
   input  logic              start,
   input  logic              loop_mode,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   input  logic [3:0]        pal_r,
   input  logic [3:0]        pal_g,
   input  logic [3:0]        pal_b,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              pixel_on,
   output logic [FI_W-1:0]   frame_idx,
   output logic              anim_done
);

   localparam int CNT_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HOLD = 2'd2} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_loop;
   logic [FI_W-1:0]     r_frame_idx;
   logic                r_anim_done;
   logic [9:0]          r_sh_x;
   logic [9:0]          r_sh_y;
   logic                r_sh_flip;
   logic [ADDR_W-1:0]   r_rom_address;
   logic                r_in_box_d;
   logic                r_blank_d;
   logic [3:0]          r_red;
   logic [3:0]          r_green;
   logic [3:0]          r_blue;
   logic                r_pixel_on;

   logic [10:0]         w_lx;
   logic [10:0]         w_ly;
   logic                w_in_box;
   logic [31:0]         w_col_raw;
   logic [31:0]         w_col;
   logic [31:0]         w_row;
   logic                w_opaque;

   // Stage-1 hitbox mapping; 11-bit differences keep off-screen boxes from wrapping into view
   always_comb begin
      w_lx      = {1'b0, DrawX} - {1'b0, r_sh_x};
      w_ly      = {1'b0, DrawY} - {1'b0, r_sh_y};
      w_in_box  = (DrawX >= r_sh_x) && (w_lx < 11'(BOX_W)) &&
                  (DrawY >= r_sh_y) && (w_ly < 11'(BOX_H));
      w_col_raw = (32'(w_lx) * 32'(SPR_W)) / 32'(BOX_W);
      w_row     = (32'(w_ly) * 32'(SPR_H)) / 32'(BOX_H);
      if (r_sh_flip) begin
         w_col = 32'(SPR_W) - 32'd1 - w_col_raw;
      end else begin
         w_col = w_col_raw;
      end
      w_opaque  = r_in_box_d && r_blank_d && (rom_q != IDX_W'(TRANSP_IDX));
   end

   // Shadow registers and the two-stage pixel pipeline
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         r_sh_x        <= 10'd0;
         r_sh_y        <= 10'd0;
         r_sh_flip     <= 1'b0;
         r_rom_address <= '0;
         r_in_box_d    <= 1'b0;
         r_blank_d     <= 1'b0;
         r_red         <= 4'd0;
         r_green       <= 4'd0;
         r_blue        <= 4'd0;
         r_pixel_on    <= 1'b0;
      end else begin
         if (frame_tick) begin
            r_sh_x    <= pos_x;
            r_sh_y    <= pos_y;
            r_sh_flip <= flip;
         end
         if (w_in_box) begin
            r_rom_address <= ADDR_W'(32'(r_frame_idx) * 32'(SPR_W*SPR_H) + w_row * 32'(SPR_W) + w_col);
         end else begin
            r_rom_address <= '0;
         end
         r_in_box_d <= w_in_box;
         r_blank_d  <= blank;
         r_red      <= w_opaque ? pal_r : 4'd0;
         r_green    <= w_opaque ? pal_g : 4'd0;
         r_blue     <= w_opaque ? pal_b : 4'd0;
         r_pixel_on <= w_opaque;
      end
   end

   // Animation sequencer; start has priority over a coincident frame_tick
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_loop      <= 1'b0;
         r_frame_idx <= '0;
         r_anim_done <= 1'b0;
      end else begin
         r_anim_done <= 1'b0;
         if (start) begin
            r_state     <= S_PLAY;
            r_cnt       <= '0;
            r_frame_idx <= '0;
            r_loop      <= loop_mode;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_frame_idx <= '0;
               end
               S_PLAY: begin
                  if (frame_tick) begin
                     if (r_cnt < CNT_W'(FRAME_HOLD-1)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end else begin
                        r_cnt <= '0;
                        if (r_frame_idx != FI_W'(NUM_FRAMES-1)) begin
                           r_frame_idx <= r_frame_idx + FI_W'(1);
                        end else if (r_loop) begin
                           r_frame_idx <= '0;
                        end else begin
                           r_anim_done <= 1'b1;
                           r_state     <= S_HOLD;
                        end
                     end
                  end
               end
               S_HOLD: begin
                  r_frame_idx <= FI_W'(NUM_FRAMES-1);
               end
               default: begin
                  r_state     <= S_IDLE;
                  r_frame_idx <= '0;
               end
            endcase
         end
      end
   end

   assign rom_address = r_rom_address;
   assign red         = r_red;
   assign green       = r_green;
   assign blue        = r_blue;
   assign pixel_on    = r_pixel_on;
   assign frame_idx   = r_frame_idx;
   assign anim_done   = r_anim_done;

endmodule
